// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic two-entry pipeline register between two CPU stages.
// Moves a PC plus an opaque payload over valid/ready handshakes, sustaining one
// transfer per cycle while in_ready stays a registered, state-decoded signal.
// Flush and reset squash every held entry; draining is strictly in order.
//
// Optional feature macro: PIPE_PERF_CNT_EN (adds bubble_cnt / stall_cnt).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   flush           squash all held entries at the next edge
//   in_valid/ready  upstream handshake (in_ready decoded from state only)
//   in_pc, in_data  upstream entry
//   out_valid/ready downstream handshake
//   out_pc/out_data head entry; RESET_PC / zero when the stage is empty
//   occupancy       held entries (0..2)
//   bubble_cnt      cycles with no valid head (PIPE_PERF_CNT_EN only)
//   stall_cnt       cycles with a valid head held by downstream (PIPE_PERF_CNT_EN only)
module pipe_stage_buf #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam logic [PC_W-1:0] BUBBLE_PC = PC_W'(RESET_PC);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              r_state;
  logic [PC_W-1:0]     r_head_pc;
  logic [DATA_W-1:0]   r_head_data;
  logic [PC_W-1:0]     r_skid_pc;
  logic [DATA_W-1:0]   r_skid_data;

  logic w_acc;
  logic w_pop;

  // Reject nonsensical widths at elaboration.
  if (DATA_W < 1 || PC_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("pipe_stage_buf: DATA_W, PC_W and CNT_W must all be at least 1");
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign occupancy = r_state;
  assign out_pc    = r_head_pc;
  assign out_data  = r_head_data;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  // Occupancy FSM with head/skid datapath; skid only fills behind a held head.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= S_EMPTY;
      r_head_pc   <= BUBBLE_PC;
      r_head_data <= '0;
      r_skid_pc   <= BUBBLE_PC;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_state     <= S_ONE;
            r_head_pc   <= in_pc;
            r_head_data <= in_data;
          end
        end
        S_ONE: begin
          if (w_acc && w_pop) begin
            r_head_pc   <= in_pc;
            r_head_data <= in_data;
          end else if (w_acc) begin
            r_state     <= S_FULL;
            r_skid_pc   <= in_pc;
            r_skid_data <= in_data;
          end else if (w_pop) begin
            r_state     <= S_EMPTY;
            r_head_pc   <= BUBBLE_PC;
            r_head_data <= '0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can move the stage.
          if (w_pop) begin
            r_state     <= S_ONE;
            r_head_pc   <= r_skid_pc;
            r_head_data <= r_skid_data;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;

  // Free-running wrap-around counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (!out_valid) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      if (out_valid && !out_ready) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 32;
  localparam logic [31:0] RPC    = 32'h0000_3000;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  stall_cnt;
`endif

  pipe_stage_buf #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .RESET_PC(RPC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_data (out_data),
    .occupancy(occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Reference model: an ordered queue of at most two entries.
  entry_t      mq[$];
  logic [31:0] m_bubble = '0;
  logic [31:0] m_stall  = '0;

  function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd1, 32'hC0DE_0000 | pc};
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model update from the values present at the active edge.
  always @(posedge clk) begin
    bit     acc;
    bit     pop;
    entry_t e;
    acc = in_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && out_ready;
    if (reset) begin
      m_bubble = '0;
      m_stall  = '0;
    end else begin
      if (mq.size() == 0) m_bubble = m_bubble + 32'd1;
      if (mq.size() > 0 && !out_ready) m_stall = m_stall + 32'd1;
    end
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.pc   = in_pc;
        e.data = in_data;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
      chk("m_in_ready",  DATA_W'(in_ready),  DATA_W'(mq.size() < 2));
      chk("m_occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
      chk("m_out_pc",    DATA_W'(out_pc),    DATA_W'((mq.size() > 0) ? mq[0].pc : RPC));
      chk("m_out_data",  out_data,           (mq.size() > 0) ? mq[0].data : '0);
`ifdef PIPE_PERF_CNT_EN
      chk("m_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bubble));
      chk("m_stall_cnt",  DATA_W'(stall_cnt),  DATA_W'(m_stall));
`endif
    end
  end

  // Hold the given inputs for one full clock, returning at the next negedge.
  task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [31:0] pc, input bit ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_data   = mk(pc);
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_out_valid"}, DATA_W'(out_valid), '0);
    chk({nm, "_in_ready"},  DATA_W'(in_ready),  DATA_W'(1));
    chk({nm, "_occ"},       DATA_W'(occupancy), '0);
    chk({nm, "_out_pc"},    DATA_W'(out_pc),    DATA_W'(32'h3000));
    chk({nm, "_out_data"},  out_data,           '0);
  endtask

  initial begin
    // 1. reset values
    cyc(1, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 1, 32'h9999, 1);
    chk_empty("rst");

    // 2. streaming: each pc appears one cycle later, occupancy stays 1
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 32'h3000 + 32'(4 * i), 1);
      chk("stream_pc",  DATA_W'(out_pc),    DATA_W'(32'h3000 + 32'(4 * i)));
      chk("stream_occ", DATA_W'(occupancy), DATA_W'(1));
      chk("stream_rdy", DATA_W'(in_ready),  DATA_W'(1));
    end
    cyc(0, 0, 0, 32'h0, 1);
    chk("stream_drain_occ", DATA_W'(occupancy), '0);

    // 3. downstream stall with A, B, C then release
    cyc(0, 0, 1, 32'h3000, 0);
    chk("stall_occ_a", DATA_W'(occupancy), DATA_W'(1));
    cyc(0, 0, 1, 32'h3004, 0);
    chk("stall_occ_b", DATA_W'(occupancy), DATA_W'(2));
    chk("stall_rdy_b", DATA_W'(in_ready),  '0);
    cyc(0, 0, 1, 32'h3008, 0);
    chk("stall_hold_pc", DATA_W'(out_pc),  DATA_W'(32'h3000));
    chk("stall_hold_data", out_data,       mk(32'h3000));
    cyc(0, 0, 1, 32'h3008, 1);
    chk("rel_pc_b",  DATA_W'(out_pc),    DATA_W'(32'h3004));
    chk("rel_occ_b", DATA_W'(occupancy), DATA_W'(1));
    cyc(0, 0, 1, 32'h3008, 1);
    chk("rel_pc_c",   DATA_W'(out_pc), DATA_W'(32'h3008));
    chk("rel_data_c", out_data,        mk(32'h3008));
    cyc(0, 0, 0, 32'h0, 1);
    chk("rel_drain_occ", DATA_W'(occupancy), '0);

    // 4. flush while full with a simultaneous offer of D
    cyc(0, 0, 1, 32'h3100, 0);
    cyc(0, 0, 1, 32'h3104, 0);
    chk("pre_flush_occ", DATA_W'(occupancy), DATA_W'(2));
    cyc(0, 1, 1, 32'h3108, 0);
    chk_empty("flush");
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    chk("flush_no_d_valid", DATA_W'(out_valid), '0);

    // 5. reset mid-stream with one entry held, then resume
    cyc(0, 0, 1, 32'h3200, 0);
    chk("mid_occ", DATA_W'(occupancy), DATA_W'(1));
    cyc(1, 0, 1, 32'h3204, 1);
    chk_empty("mid_rst");
    cyc(0, 0, 1, 32'h3208, 0);
    chk("resume_pc",  DATA_W'(out_pc),    DATA_W'(32'h3208));
    chk("resume_occ", DATA_W'(occupancy), DATA_W'(1));

`ifdef PIPE_PERF_CNT_EN
    // 6. three empty cycles (last one accepts) then four stalled cycles
    cyc(1, 0, 0, 32'h0, 0);
    chk("perf_rst_bubble", DATA_W'(bubble_cnt), '0);
    chk("perf_rst_stall",  DATA_W'(stall_cnt),  '0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'h3300, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 0);
    chk("perf_bubble", DATA_W'(bubble_cnt), DATA_W'(3));
    chk("perf_stall",  DATA_W'(stall_cnt),  DATA_W'(4));
    cyc(0, 1, 0, 32'h0, 1);
    chk("perf_flush_bubble", DATA_W'(bubble_cnt), DATA_W'(3));
    chk("perf_flush_stall",  DATA_W'(stall_cnt),  DATA_W'(4));
    cyc(1, 0, 0, 32'h0, 0);
    chk("perf_clr_bubble", DATA_W'(bubble_cnt), '0);
    chk("perf_clr_stall",  DATA_W'(stall_cnt),  '0);
`endif

    cyc(0, 0, 0, 32'h0, 1);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic successor to the fixed D/E pipeline register. Carries a PC plus an opaque payload bus between two CPU pipeline stages using valid/ready handshakes. A 2-entry skid store lets it sustain one transfer per cycle while in_ready stays a registered signal. It supports flush (bubble insertion) and drains strictly in order.

Parameters:
DATA_W, 128, payload width in bits (instr, rd1, rd2, imm, a3 etc. concatenated by the instantiating stage).
PC_W, 32, PC field width.
RESET_PC, 32'h00003000, PC value presented on out_pc whenever the stage holds a bubble (truncated/zero-extended to PC_W).
CNT_W, 32, width of the performance counters (only used with PIPE_PERF_CNT_EN).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  squash all held entries; takes effect at the next edge.
in_valid  input  1  upstream presents an entry.
in_ready  output  1  registered; stage can accept an entry this cycle.
in_pc  input  PC_W  upstream PC.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts the head this cycle.
out_pc  output  PC_W  head PC; RESET_PC when empty.
out_data  output  DATA_W  head payload; all-zero when empty.
occupancy  output  2  number of held entries: 0, 1 or 2.
bubble_cnt  output  CNT_W  only with PIPE_PERF_CNT_EN.
stall_cnt  output  CNT_W  only with PIPE_PERF_CNT_EN.

Behaviour:
- Registers:
  - head (pc, data) drives out_pc/out_data directly; no combinational gating on outputs.
  - skid (pc, data) holds the second entry.
- State machine: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), decoded from state only; no combinational path from out_ready or in_valid.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Transitions when reset=0 and flush=0:
  - EMPTY: acc → ONE, head <= in. Otherwise hold.
  - ONE, acc & pop → ONE, head <= in.
  - ONE, acc only → FULL, skid <= in.
  - ONE, pop only → EMPTY, head <= bubble.
  - ONE, neither → hold.
  - FULL: pop → ONE, head <= skid. Otherwise hold. in_ready is 0, so no accept.
- Bubble value: pc = RESET_PC, data = 0.
- Latency: an entry accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when ONE with a simultaneous pop.
- Ordering: strict FIFO. The skid entry never overtakes head.
- Held entries stay stable while out_ready=0 (stall). in_data changes do not disturb held entries.
- reset or flush (reset has priority; both behave identically on the datapath):
  - Next state is EMPTY; head and skid <= bubble.
  - Any acc in that same cycle is discarded.
  - A pop in that same cycle still counts as completed downstream.
- Reset mid-operation discards all entries with no partial drain.
- After reset: out_valid=0, in_ready=1, occupancy=0, out_pc=RESET_PC, out_data=0, counters=0.
- in_valid asserted while in_ready=0 has no effect. Upstream holds its data.

Optional Feature:
PIPE_PERF_CNT_EN defined:
- bubble_cnt increments each cycle with out_valid=0 and reset=0.
- stall_cnt increments each cycle with out_valid=1 & out_ready=0.
- Both counters wrap modulo 2^CNT_W, clear on reset, and do not clear on flush.

PIPE_PERF_CNT_EN undefined: the counter ports and logic are absent.

Test Plan:
1. Reset values: assert reset 2 cycles → out_valid=0, in_ready=1, occupancy=0, out_pc=0x3000, out_data=0.
2. Streaming: in_valid=1 and out_ready=1 continuously, pc=0x3000,0x3004,... → each pc on out_pc one cycle later, one per cycle, occupancy stays 1, in_ready never drops.
3. Downstream stall: hold out_ready=0 and push A(0x3000), B(0x3004), C(0x3008) → occupancy goes 1 then 2, in_ready=0 after B, C stays pending. Then release out_ready → out order A, B, C with no loss.
4. Flush while FULL plus simultaneous in_valid(D) → next cycle occupancy=0, out_pc=0x3000, out_data=0, D never appears.
5. Reset asserted mid-stream with occupancy=1 → identical to scenario 1 on the next cycle. Resumes cleanly with the next input.
6. With PIPE_PERF_CNT_EN: 3 empty cycles then 4 stalled cycles → bubble_cnt=3, stall_cnt=4. Flush → counts retained. Reset → both 0.
